// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: digit count, the
// active-low hex glyph set ({g,f,e,d,c,b,a}) and the all-dark pattern.
package seg7_pkg;

   localparam int DIGITS = 4;

   localparam logic [6:0] SEG_DARK = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'b1000000;
   localparam logic [6:0] GLYPH_1 = 7'b1111001;
   localparam logic [6:0] GLYPH_2 = 7'b0100100;
   localparam logic [6:0] GLYPH_3 = 7'b0110000;
   localparam logic [6:0] GLYPH_4 = 7'b0011001;
   localparam logic [6:0] GLYPH_5 = 7'b0010010;
   localparam logic [6:0] GLYPH_6 = 7'b0000010;
   localparam logic [6:0] GLYPH_7 = 7'b1111000;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0010000;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b0000011;
   localparam logic [6:0] GLYPH_C = 7'b1000110;
   localparam logic [6:0] GLYPH_D = 7'b0100001;
   localparam logic [6:0] GLYPH_E = 7'b0000110;
   localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder, active-low {g,f,e,d,c,b,a}.
// Shared by every block that drives a seven-segment digit.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = SEG_DARK;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = SEG_DARK;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver: latches a 16-bit value and scans
// one digit every CLK_DIV cycles. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame
);

   localparam int         DIV_W    = $clog2(CLK_DIV);
   localparam logic [1:0] IDX_LAST = 2'(DIGITS - 1);

   logic [DIV_W-1:0] div;
   logic [1:0]       idx;
   logic [15:0]      disp;
   logic             wrap_q;
   logic             tick;
   logic             blank;
   logic [3:0]       nibble;
   logic [6:0]       glyph;

   assign tick   = (div == DIV_W'(CLK_DIV - 1));
   assign nibble = disp[{idx, 2'b00} +: 4];

   seg7_hex_decode u_decode (
      .nibble (nibble),
      .glyph  (glyph)
   );

`ifdef SEG7_LZ_BLANK_EN
   // A digit goes dark only when it and every more-significant digit are zero.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd1:    blank = (disp[15:4]  == 12'd0);
         2'd2:    blank = (disp[15:8]  == 8'd0);
         2'd3:    blank = (disp[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   // an/seg are registered from the pre-edge idx, so the digit-0 enable appears
   // one edge after the wrapping tick; frame is delayed one stage to line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         div    <= '0;
         idx    <= '0;
         disp   <= '0;
         wrap_q <= 1'b0;
         an     <= 4'hF;
         seg    <= SEG_DARK;
         frame  <= 1'b0;
      end else begin
         if (load) begin
            disp <= value;
         end
         div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            idx <= idx + 2'd1;
         end
         wrap_q <= tick && (idx == IDX_LAST);
         frame  <= wrap_q;
         an     <= blank ? 4'hF : ~(4'b0001 << idx);
         seg    <= blank ? SEG_DARK : glyph;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a CLK_DIV=4 instance and a CLK_DIV=2 instance
// share stimulus; expectations come from hand-computed tables and cycle counts.
module tb_seg7_scan;

`ifdef SEG7_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic [6:0]  seg4, seg2;
   logic [3:0]  an4, an2;
   logic        frame4, frame2;

   int tests;
   int fails;
   int cur_k;

   seg7_scan #(.CLK_DIV(4)) u_div4 (
      .clk(clk), .rst(rst), .value(value), .load(load),
      .seg(seg4), .an(an4), .frame(frame4)
   );

   seg7_scan #(.CLK_DIV(2)) u_div2 (
      .clk(clk), .rst(rst), .value(value), .load(load),
      .seg(seg2), .an(an2), .frame(frame2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      int          k;
      logic [3:0]  an;
      logic [6:0]  seg;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got {an,seg,frame}=%b_%b_%b expected %b_%b_%b (t=%0t)",
                  name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], $time);
      end
   endtask

   // Reset for two edges, then release; the first edge after release is k=1.
   task automatic start_scan(input logic [15:0] v, input bit do_load);
      rst   = 1'b1;
      load  = 1'b0;
      value = '0;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      load  = do_load;
      value = v;
      @(negedge clk);
      load  = 1'b0;
      cur_k = 1;
   endtask

   task automatic step_to(input int k);
      while (cur_k < k) begin
         @(negedge clk);
         cur_k++;
      end
   endtask

   // Expected {an,seg,frame} at edge k after release for a display of all zeros.
   function automatic logic [11:0] zero_exp(input int k, input int dwell);
      int         d;
      logic [3:0] a;
      logic [6:0] s;
      logic       f;
      d = ((k - 1) / dwell) % 4;
      a = 4'b1111;
      a[d] = 1'b0;
      s = 7'b1000000;
      if (LZ && d != 0) begin
         a = 4'b1111;
         s = 7'b1111111;
      end
      f = (k > 4 * dwell) && ((k - 1) % (4 * dwell) == 0);
      return {a, s, f};
   endfunction

   initial begin
      tests = 0;
      fails = 0;
      cur_k = 0;
      rst   = 1'b1;
      load  = 1'b0;
      value = '0;

      vecs[0]  = '{16'h1A3F, 2,  4'b1110, 7'b0001110};
      vecs[1]  = '{16'h1A3F, 4,  4'b1110, 7'b0001110};
      vecs[2]  = '{16'h1A3F, 6,  4'b1101, 7'b0110000};
      vecs[3]  = '{16'h1A3F, 10, 4'b1011, 7'b0001000};
      vecs[4]  = '{16'h1A3F, 14, 4'b0111, 7'b1111001};
      vecs[5]  = '{16'h1A3F, 17, 4'b1110, 7'b0001110};
      vecs[6]  = '{16'h0042, 2,  4'b1110, 7'b0100100};
      vecs[7]  = '{16'h0042, 6,  4'b1101, 7'b0011001};
      vecs[8]  = LZ ? '{16'h0042, 10, 4'b1111, 7'b1111111} : '{16'h0042, 10, 4'b1011, 7'b1000000};
      vecs[9]  = LZ ? '{16'h0042, 14, 4'b1111, 7'b1111111} : '{16'h0042, 14, 4'b0111, 7'b1000000};
      vecs[10] = '{16'h0000, 2,  4'b1110, 7'b1000000};
      vecs[11] = LZ ? '{16'h0000, 6, 4'b1111, 7'b1111111} : '{16'h0000, 6, 4'b1101, 7'b1000000};

      // Reset state on both instances.
      repeat (2) @(negedge clk);
      check("reset_div4", {an4, seg4, frame4}, {4'b1111, 7'b1111111, 1'b0});
      check("reset_div2", {an2, seg2, frame2}, {4'b1111, 7'b1111111, 1'b0});

      // Free-running scan with no load: dwell, digit order and frame period.
      start_scan(16'h0000, 1'b0);
      for (int k = 1; k <= 36; k++) begin
         step_to(k);
         check($sformatf("scan_div4_k%0d", k), {an4, seg4, frame4}, zero_exp(k, 4));
         check($sformatf("scan_div2_k%0d", k), {an2, seg2, frame2}, zero_exp(k, 2));
      end

      // Table of loaded values sampled at chosen edges on the CLK_DIV=4 instance.
      for (int i = 0; i < 12; i++) begin
         start_scan(vecs[i].val, 1'b1);
         step_to(vecs[i].k);
         check($sformatf("vec%0d_%h_k%0d", i, vecs[i].val, vecs[i].k),
               {an4, seg4, frame4},
               {vecs[i].an, vecs[i].seg, (vecs[i].k == 17) ? 1'b1 : 1'b0});
      end

      // Load on the tick that moves digit 1 -> 2 (edge 8): the next digit uses 0005.
      start_scan(16'h1A3F, 1'b1);
      step_to(7);
      load  = 1'b1;
      value = 16'h0005;
      @(negedge clk);
      cur_k = 8;
      load  = 1'b0;
      check("tickload_k8", {an4, seg4, frame4}, {4'b1101, 7'b0110000, 1'b0});
      for (int k = 9; k <= 16; k++) begin
         step_to(k);
         if (LZ)
            check($sformatf("tickload_k%0d", k), {an4, seg4, frame4}, {4'b1111, 7'b1111111, 1'b0});
         else
            check($sformatf("tickload_k%0d", k), {an4, seg4, frame4},
                  {(k <= 12) ? 4'b1011 : 4'b0111, 7'b1000000, 1'b0});
      end
      step_to(17);
      check("tickload_k17", {an4, seg4, frame4}, {4'b1110, 7'b0010010, 1'b1});

      // Reset while digit 2 is selected; value is lost and the scan restarts at digit 0.
      start_scan(16'h1A3F, 1'b1);
      step_to(10);
      check("midrst_before", {an4, seg4, frame4}, {4'b1011, 7'b0001000, 1'b0});
      rst = 1'b1;
      @(negedge clk);
      check("midrst_edge", {an4, seg4, frame4}, {4'b1111, 7'b1111111, 1'b0});
      rst = 1'b0;
      @(negedge clk);
      cur_k = 1;
      for (int k = 1; k <= 6; k++) begin
         step_to(k);
         check($sformatf("midrst_restart_k%0d", k), {an4, seg4, frame4}, zero_exp(k, 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
